// File: rtl/spi_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one 16-bit SPI master between two requesters.
// Launches one transaction at a time, returns the read word with a one-cycle ack, and enforces idle gap and timeout.
module spi_arb_ctrl #(
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] cmd0,
    input  logic        req1,
    input  logic [15:0] cmd1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        mstr_wrt,
    output logic [15:0] mstr_cmd,
    input  logic        mstr_done,
    input  logic [15:0] mstr_rd_data,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_CLR  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4,
        GAP       = 3'd5
    } state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);
    localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYC);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] mstr_cmd_q, mstr_cmd_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            mstr_cmd_q   <= 16'h0000;
            rdata_q      <= 16'h0000;
            err_q        <= 1'b0;
            to_cnt_q     <= 16'h0000;
            gap_cnt_q    <= 8'h00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            mstr_cmd_q   <= mstr_cmd_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            // Done is flopped once on entry, so done-to-ack is two cycles.
            done_q       <= mstr_done;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        mstr_cmd_d   = mstr_cmd_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        to_cnt_d     = to_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Fairness pointer only moves when both ports contend.
                    if (req0 && req1) begin
                        gnt_d        = ~last_grant_q;
                        last_grant_d = ~last_grant_q;
                    end else begin
                        gnt_d = req1;
                    end
                    mstr_cmd_d = gnt_d ? cmd1 : cmd0;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                to_cnt_d = 16'h0000;
                state_d  = WAIT_CLR;
            end
            WAIT_CLR, WAIT_DONE: begin
                to_cnt_d = to_cnt_q + 16'd1;
                if (to_cnt_d == TO_LIMIT) begin
                    rdata_d = 16'h0000;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (state_q == WAIT_CLR) begin
                    if (!done_q) state_d = WAIT_DONE;
                end else if (done_q) begin
                    rdata_d = mstr_rd_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                gap_cnt_d = GAP_LOAD;
                state_d   = GAP;
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q <= 8'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack0      = (state_q == RESP) && !gnt_q;
    assign ack1      = (state_q == RESP) && gnt_q;
    assign mstr_wrt  = (state_q == LAUNCH);
    assign busy      = (state_q != IDLE);
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mstr_cmd  = mstr_cmd_q;
    assign dbg_state = state_q;

endmodule
